// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the HI/LO multiply/divide unit
// Contents:
//   state_e     : sequencer states (IDLE, MUL, DIV, FIX)
//   op_e        : operation kind decoded from Mul/Div at start
//   DBZ_LO_BIT  : fill bit for LO on divide-by-zero, replicated to WIDTH at use
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  localparam logic DBZ_LO_BIT = 1'b1;

endpackage

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - iterative signed/unsigned multiply/divide unit owning HI/LO
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   start, Mul, Div     : launch an operation (accepted in IDLE only; Mul wins if both)
//   Unsigned            : operands unsigned when 1, two's complement when 0
//   WriteHi, WriteLo    : load hi/lo from op1 when idle and not starting
//   op1, op2            : rs / rt operands
//   busy, done          : operation in flight / one-cycle result-valid pulse
//   hi, lo              : HI/LO registers
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Mul,
  input  logic             Div,
  input  logic             Unsigned,
  input  logic             WriteHi,
  input  logic             WriteLo,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   dvsr_q;   // multiplicand magnitude (MUL) or divisor magnitude (DIV)
  logic [2*WIDTH-1:0] acc_q;    // MUL: {partial, multiplier}; DIV: {remainder, dividend/quotient}
  logic               neg_q;    // product / quotient sign
  logic               rneg_q;   // remainder sign
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  op_e                op_sel;
  logic               sgn1;
  logic               sgn2;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    op_sel = Mul ? OP_MUL : OP_DIV;
    sgn1   = op1[WIDTH-1] & ~Unsigned;
    sgn2   = op2[WIDTH-1] & ~Unsigned;
    mag1   = sgn1 ? (WIDTH'(0) - op1) : op1;
    mag2   = sgn2 ? (WIDTH'(0) - op2) : op2;

    // Shift-add: add multiplicand into the upper half when the multiplier LSB is set,
    // keeping the carry so the right shift does not lose it.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
    // Restoring divide: trial-subtract from the remainder shifted left by one.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvsr_q};

    if (state_q == DIV) begin
      step_acc = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                  : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Sign correction works on the final step's output so hi/lo already hold the
    // result during the FIX cycle, when done is high.
    prod_fix = neg_q  ? ((2*WIDTH)'(0) - step_acc) : step_acc;
    quo_fix  = neg_q  ? (WIDTH'(0) - step_acc[WIDTH-1:0]) : step_acc[WIDTH-1:0];
    rem_fix  = rneg_q ? (WIDTH'(0) - step_acc[2*WIDTH-1:WIDTH]) : step_acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvsr_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && (Mul || Div)) begin
            if (op_sel == OP_DIV && op2 == '0) begin
              hi_q   <= op1;
              lo_q   <= {WIDTH{DBZ_LO_BIT}};
              done_q <= 1'b1;
            end else begin
              cnt_q  <= '0;
              neg_q  <= sgn1 ^ sgn2;
              rneg_q <= sgn1;
              if (op_sel == OP_MUL) begin
                dvsr_q  <= mag1;
                acc_q   <= {{WIDTH{1'b0}}, mag2};
                state_q <= MUL;
              end else begin
                dvsr_q  <= mag2;
                acc_q   <= {{WIDTH{1'b0}}, mag1};
                state_q <= DIV;
              end
            end
          end else if (!start) begin
            if (WriteHi) hi_q <= op1;
            if (WriteLo) lo_q <= op1;
          end
        end
        MUL, DIV: begin
          acc_q <= step_acc;
          if (cnt_q == CNT_LAST) begin
            if (state_q == MUL) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
            done_q  <= 1'b1;
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - directed self-checking bench for hilo_muldiv (WIDTH=32)
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        Mul;
  logic        Div;
  logic        Unsigned;
  logic        WriteHi;
  logic        WriteLo;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .Mul      (Mul),
    .Div      (Div),
    .Unsigned (Unsigned),
    .WriteHi  (WriteHi),
    .WriteLo  (WriteLo),
    .op1      (op1),
    .op2      (op2),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, optionally injecting a stray start (inj_s) or WriteHi (inj_w)
  // at busy cycle inj_cyc. Returns cycles to done, busy cycles, and busy one
  // cycle after done (the IDLE cycle where a new start is legal).
  task automatic run_op(input logic m, input logic d, input logic u,
                        input logic [31:0] a, input logic [31:0] b,
                        input int inj_cyc, input logic inj_s, input logic inj_w,
                        output int lat, output int busy_cyc, output logic busy_after);
    Mul = m; Div = d; Unsigned = u; op1 = a; op2 = b; start = 1'b1;
    tick();
    start = 1'b0; Mul = 1'b0; Div = 1'b0; Unsigned = 1'b0;
    lat = 1;
    busy_cyc = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cyc++;
      if (lat == inj_cyc) begin
        start = inj_s; Mul = inj_s; WriteHi = inj_w; op1 = 32'h0000_1234; op2 = 32'h3;
      end
      tick();
      start = 1'b0; Mul = 1'b0; WriteHi = 1'b0;
      lat++;
    end
    if (busy) busy_cyc++;
    tick();
    busy_after = busy;
  endtask

  int   lat;
  int   bc;
  logic ba;

  initial begin
    reset = 1'b0; start = 1'b0; Mul = 1'b0; Div = 1'b0; Unsigned = 1'b0;
    WriteHi = 1'b0; WriteLo = 1'b0; op1 = '0; op2 = '0;
    tick(); tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hi",   64'(hi),   64'd0);
    check_eq("rst_lo",   64'(lo),   64'd0);
    reset = 1'b1;
    tick();

    // -3 x 5 signed
    run_op(1, 0, 0, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, lat, bc, ba);
    check_eq("smul_lat",   64'(lat), 64'd33);
    check_eq("smul_busy",  64'(bc),  64'd33);
    check_eq("smul_hi",    64'(hi),  64'hFFFF_FFFF);
    check_eq("smul_lo",    64'(lo),  64'hFFFF_FFF1);
    check_eq("smul_idle",  64'(ba),  64'd0);

    // unsigned max x max, back-to-back, with a stray start mid-MUL
    run_op(1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1, 0, lat, bc, ba);
    check_eq("umul_lat", 64'(lat), 64'd33);
    check_eq("umul_hi",  64'(hi),  64'hFFFF_FFFE);
    check_eq("umul_lo",  64'(lo),  64'h0000_0001);

    // same operands signed: -1 x -1
    run_op(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, lat, bc, ba);
    check_eq("smul11_hi", 64'(hi), 64'h0);
    check_eq("smul11_lo", 64'(lo), 64'h1);

    // -7 / 2 signed with a stray WriteHi mid-DIV
    run_op(0, 1, 0, 32'hFFFF_FFF9, 32'd2, 10, 0, 1, lat, bc, ba);
    check_eq("sdiv_lat", 64'(lat), 64'd33);
    check_eq("sdiv_lo",  64'(lo),  64'hFFFF_FFFD);
    check_eq("sdiv_hi",  64'(hi),  64'hFFFF_FFFF);

    // WriteHi in IDLE
    WriteHi = 1'b1; op1 = 32'h0000_1234;
    tick();
    WriteHi = 1'b0; op1 = '0;
    check_eq("mthi_hi",   64'(hi),   64'h0000_1234);
    check_eq("mthi_lo",   64'(lo),   64'hFFFF_FFFD);
    check_eq("mthi_done", 64'(done), 64'd0);

    // WriteHi and WriteLo together
    WriteHi = 1'b1; WriteLo = 1'b1; op1 = 32'h0000_0055;
    tick();
    WriteHi = 1'b0; WriteLo = 1'b0;
    check_eq("mthilo_hi", 64'(hi), 64'h55);
    check_eq("mthilo_lo", 64'(lo), 64'h55);

    // min / -1 signed wraps
    run_op(0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, lat, bc, ba);
    check_eq("minneg_lo", 64'(lo), 64'h8000_0000);
    check_eq("minneg_hi", 64'(hi), 64'h0);

    // unsigned 100 / 7
    run_op(0, 1, 1, 32'd100, 32'd7, 0, 0, 0, lat, bc, ba);
    check_eq("udiv_lo", 64'(lo), 64'd14);
    check_eq("udiv_hi", 64'(hi), 64'd2);

    // 10 / 0
    run_op(0, 1, 0, 32'd10, 32'd0, 0, 0, 0, lat, bc, ba);
    check_eq("dbz_lat",  64'(lat), 64'd1);
    check_eq("dbz_busy", 64'(bc),  64'd0);
    check_eq("dbz_hi",   64'(hi),  64'h0000_000A);
    check_eq("dbz_lo",   64'(lo),  64'hFFFF_FFFF);

    // reset at cycle 10 of a DIV
    Div = 1'b1; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; Div = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check_eq("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_hi",   64'(hi),   64'd0);
    check_eq("abort_lo",   64'(lo),   64'd0);

    // 2 x 3 after abort
    run_op(1, 0, 0, 32'd2, 32'd3, 0, 0, 0, lat, bc, ba);
    check_eq("post_lat", 64'(lat), 64'd33);
    check_eq("post_lo",  64'(lo),  64'd6);
    check_eq("post_hi",  64'(hi),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
